// File: rtl/freq_disp_ctrl.sv
// freq_disp_ctrl: shift-add-3 BCD conversion, auto-ranging 4-digit window and scan clock for a 7-segment frequency display
module freq_disp_ctrl #(
  parameter int CNT_W    = 24,
  parameter int SCAN_DIV = 25000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [CNT_W-1:0] count,
  input  logic             count_valid,
  output logic             busy,
  output logic             upd,
  output logic [3:0]       l_0,
  output logic [3:0]       l_1,
  output logic [3:0]       l_2,
  output logic [3:0]       l_3,
  output logic             DP_1,
  output logic             DP_2,
  output logic             DP_3,
  output logic [1:0]       range,
  output logic             clock_led
);
  localparam int PW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  localparam int IW = $clog2(CNT_W + 1);
  typedef enum logic [1:0] {IDLE, CONV, LOAD} state_t;
  state_t           r_state;
  logic [PW-1:0]    r_pre;
  logic [CNT_W-1:0] r_sh;
  logic [CNT_W-1:0] r_pend;
  logic             r_pend_v;
  logic [31:0]      r_bcd;
  logic [IW-1:0]    r_iter;
  logic [31:0]      w_adj;
  logic [15:0]      w_win;
  logic [2:0]       w_dp;
  logic [1:0]       w_rng;
  for (genvar i = 0; i < 8; i++) begin : g_adj
    assign w_adj[4*i+:4] = r_bcd[4*i+:4] >= 4'd5 ? r_bcd[4*i+:4] + 4'd3 : r_bcd[4*i+:4];
  end
  assign w_rng = |r_bcd[31:28] ? 2'd3 : |r_bcd[27:24] ? 2'd2 : |r_bcd[23:16] ? 2'd1 : 2'd0;
  assign w_win = |r_bcd[31:28] ? r_bcd[31:16] :
                 |r_bcd[27:24] ? r_bcd[27:12] :
                 |r_bcd[23:20] ? r_bcd[23:8]  :
                 |r_bcd[19:16] ? r_bcd[19:4]  : r_bcd[15:0];
  assign w_dp  = w_rng != 2'd1 ? 3'b000 : |r_bcd[23:20] ? 3'b001 : 3'b010;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pre     <= '0;
      clock_led <= 1'b0;
    end else if (r_pre == PW'(SCAN_DIV - 1)) begin
      r_pre     <= '0;
      clock_led <= ~clock_led;
    end else begin
      r_pre <= r_pre + 1'b1;
    end
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_sh     <= '0;
      r_pend   <= '0;
      r_pend_v <= 1'b0;
      r_bcd    <= '0;
      r_iter   <= '0;
      busy     <= 1'b0;
      upd      <= 1'b0;
      {l_3, l_2, l_1, l_0} <= '0;
      {DP_3, DP_2, DP_1}   <= '0;
      range    <= '0;
    end else begin
      upd <= 1'b0;
      case (r_state)
        IDLE: if (count_valid) begin
          r_sh    <= count;
          r_bcd   <= '0;
          r_iter  <= '0;
          busy    <= 1'b1;
          r_state <= CONV;
        end
        CONV: begin
          {r_bcd, r_sh} <= {w_adj, r_sh} << 1;
          r_iter        <= r_iter + 1'b1;
          if (count_valid) begin
            r_pend   <= count;
            r_pend_v <= 1'b1;
          end
          if (r_iter == IW'(CNT_W - 1)) r_state <= LOAD;
        end
        default: begin
          {l_3, l_2, l_1, l_0} <= w_win;
          {DP_3, DP_2, DP_1}   <= w_dp;
          range    <= w_rng;
          upd      <= 1'b1;
          r_pend_v <= 1'b0;
          // a strobe landing on this edge is newer than anything pending
          if (count_valid || r_pend_v) begin
            r_sh    <= count_valid ? count : r_pend;
            r_bcd   <= '0;
            r_iter  <= '0;
            r_state <= CONV;
          end else begin
            busy    <= 1'b0;
            r_state <= IDLE;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_freq_disp_ctrl.sv
// tb_freq_disp_ctrl: randomized and directed checks against a cycle-timeline model of the display controller
module tb_freq_disp_ctrl;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [23:0] count = '0;
  logic        count_valid = 1'b0;
  logic        busy, upd, DP_1, DP_2, DP_3, clock_led;
  logic [3:0]  l_0, l_1, l_2, l_3;
  logic [1:0]  range;
  logic [20:0] w_disp;
  int n_tests = 0;
  int n_fail  = 0;
  longint      n_edge;
  bit          m_active, m_pv, m_upd;
  longint      m_load_at;
  int unsigned m_cur, m_pval;
  logic [20:0] m_disp;
  freq_disp_ctrl #(.CNT_W(24), .SCAN_DIV(4)) dut (
    .clock(clock), .reset(reset), .count(count), .count_valid(count_valid),
    .busy(busy), .upd(upd), .l_0(l_0), .l_1(l_1), .l_2(l_2), .l_3(l_3),
    .DP_1(DP_1), .DP_2(DP_2), .DP_3(DP_3), .range(range), .clock_led(clock_led)
  );
  assign w_disp = {l_3, l_2, l_1, l_0, DP_3, DP_2, DP_1, range};
  always #5 clock = ~clock;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, n_edge);
    end
  endtask
  function automatic logic [20:0] disp(input int unsigned v);
    int unsigned d[8];
    int unsigned t = v;
    int k = -1;
    int s;
    logic [2:0] dp;
    logic [1:0] rg;
    for (int i = 0; i < 8; i++) begin
      d[i] = t % 10;
      t = t / 10;
    end
    for (int i = 4; i < 8; i++) if (d[i] != 0) k = i;
    s  = k < 0 ? 0 : k - 3;
    dp = k == 4 ? 3'b010 : k == 5 ? 3'b001 : 3'b000;
    rg = k < 0 ? 2'd0 : k == 7 ? 2'd3 : k == 6 ? 2'd2 : 2'd1;
    return {4'(d[s+3]), 4'(d[s+2]), 4'(d[s+1]), 4'(d[s]), dp, rg};
  endfunction
  task automatic model_reset();
    n_edge = 0; m_active = 0; m_pv = 0; m_upd = 0; m_disp = '0;
  endtask
  task automatic model_start(input int unsigned v);
    m_active = 1; m_cur = v; m_load_at = n_edge + 25;
  endtask
  task automatic step(input bit sv, input int unsigned v);
    count_valid = sv;
    count = 24'(v);
    @(posedge clock);
    n_edge++;
    m_upd = 0;
    if (m_active && n_edge == m_load_at) begin
      m_disp = disp(m_cur);
      m_upd  = 1;
      if (sv) model_start(v);
      else if (m_pv) model_start(m_pval);
      else m_active = 0;
      m_pv = 0;
    end else if (m_active) begin
      if (sv) begin m_pv = 1; m_pval = v; end
    end else if (sv) begin
      model_start(v);
    end
    #1;
    count_valid = 1'b0;
    check("upd", 32'(upd), 32'(m_upd));
    check("busy", 32'(busy), 32'(m_active));
    check("disp", 32'(w_disp), 32'(m_disp));
    check("clock_led", 32'(clock_led), 32'((n_edge / 4) % 2));
  endtask
  task automatic idle(input int n);
    repeat (n) step(0, 0);
  endtask
  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("rst_disp", 32'(w_disp), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_upd", 32'(upd), 32'd0);
    check("rst_led", 32'(clock_led), 32'd0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    model_reset();
  endtask
  function automatic int unsigned rand_val();
    int unsigned b[10] = '{0, 9999, 10000, 99999, 100000, 999999, 1000000, 9999999, 10000000, 16777215};
    int unsigned p = 1;
    int unsigned c = $urandom_range(1, 8);
    if ($urandom_range(0, 4) == 0) return b[$urandom_range(0, 9)];
    repeat (c) p = p * 10;
    return ($urandom % p) % 32'd16777216;
  endfunction
  initial begin
    model_reset();
    do_reset();
    step(1, 1234);     idle(30);
    step(1, 12345);    idle(30);
    step(1, 999999);   idle(30);
    step(1, 1234567);  idle(30);
    step(1, 16777215); idle(30);
    step(1, 0);        idle(30);
    step(1, 100); idle(5); step(1, 200); idle(3); step(1, 300); idle(60);
    step(1, 5000); idle(10); do_reset();
    step(1, 42); idle(30);
    step(1, 7); idle(24); step(1, 8); idle(30);
    for (int i = 0; i < 3000; i++) step($urandom_range(0, 7) == 0, rand_val());
    idle(60);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
